instr_fetch_stage: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter. Accepts a 32-bit word address from the PC with a valid/ready handshake and issues one read at a time to instruction memory over a req/ack handshake. Returned instructions, tagged with their address, are buffered in a small FIFO and presented to the decode stage with a valid/ready handshake. A flush input discards everything in flight for branch redirects.

---
 rtl/instr_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Purpose: instruction fetch stage. Takes a word address from the PC, issues one imem read at a time and buffers tagged results for decode.
// Latency: PC accepted at edge T, imem_req high from T+1, result visible on ir_valid from T+2 when the ack arrives in T+1 and the buffer was empty.
// Backpressure: pc_ready drops while a read is outstanding, during flush, or when the output buffer is full. Decode stalls the buffer with ir_ready=0.
//
// Ports:
//   clk, rst                  rising-edge clock; synchronous active-high reset
//   pc_in/pc_valid/pc_ready   word address from the program counter (valid/ready)
//   imem_addr/imem_req        registered read address and request, held until imem_ack
//   imem_ack/imem_data        read completion and instruction data
//   ir_out/ir_pc/ir_valid     buffer head to decode (instruction, its address, non-empty)
//   ir_ready                  decode consumes the head this cycle
//   flush                     discard buffered entries and any in-flight result
//   fetch_count               instructions delivered to decode
// Build option: define IF_FETCH_COUNT_EN to implement fetch_count. Otherwise it is tied to 0.

module instr_fetch_stage #(
  parameter int ADDR_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               flush,
  output logic [31:0]        fetch_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // WAIT keeps the returning word; DRAIN only waits out a request that a flush has orphaned.
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t state, state_nxt;
  logic   req_nxt;
  logic   accept, push, pop;

  logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;

  assign pc_ready = (state == IDLE) && !flush && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept   = pc_valid && pc_ready;
  assign ir_valid = (fifo_count != '0);
  assign ir_out   = fifo_instr[rd_ptr];
  assign ir_pc    = fifo_pc[rd_ptr];
  assign pop      = ir_valid && ir_ready;

  always_comb begin
    state_nxt = state;
    req_nxt   = imem_req;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          // The memory request cannot be withdrawn; without an ack we must wait it out.
          if (imem_ack) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (imem_ack) begin
          push      = 1'b1;
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // imem_addr doubles as the tag stored with the returned instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state    <= state_nxt;
      imem_req <= req_nxt;
      if (accept) imem_addr <= pc_in;
    end
  end

  // A push can never meet a full buffer: acceptance already required a free slot
  // and only pops or a flush can change occupancy while the read is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_data;
        fifo_pc[wr_ptr]    <= imem_addr;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  // Counts every decode handshake, and survives flush.
  always_ff @(posedge clk) begin
    if (rst)      fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: an outstanding-read flag, a keep/discard flag, the address
  // in flight, and a queue of {pc, instr} entries waiting for decode.
  bit          m_busy = 0;
  bit          m_keep = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_q[$];
  logic [31:0] m_cnt = '0;
  int          m_wait = 0;
  int          ack_delay = 0;

  instr_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .flush(flush), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic bit exp_pc_ready();
    return !m_busy && !flush && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef IF_FETCH_COUNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Apply one cycle of stimulus; the memory answers ack_delay cycles after its request rose.
  task automatic drive(input bit pv, input logic [31:0] pc, input bit rdy, input bit fl);
    pc_valid  = pv;
    pc_in     = pc;
    ir_ready  = rdy;
    flush     = fl;
    imem_ack  = m_busy && (m_wait >= ack_delay);
    imem_data = imem_ack ? mem_word(m_addr) : $urandom;
    #1;
  endtask

  // Advance one clock edge and update the model with the inputs present at that edge.
  task automatic tick();
    bit acc, pop, push;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 0; m_keep = 0; m_addr = '0; m_q.delete(); m_cnt = '0; m_wait = 0;
    end else begin
      acc  = pc_valid && exp_pc_ready();
      pop  = (m_q.size() > 0) && ir_ready;
      push = 0;
      if (pop) m_cnt++;
      if (m_busy && imem_ack) begin
        push   = m_keep && !flush;
        m_busy = 0;
      end else if (m_busy && flush) begin
        m_keep = 0;
      end
      if (flush) m_q.delete();
      else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({m_addr, imem_data});
      end
      if (acc) begin
        m_busy = 1; m_keep = 1; m_addr = pc_in; m_wait = 0;
      end else if (m_busy) begin
        m_wait++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, '0, 0, 0);
    checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL reset_imem_req: got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'd0)   begin errors++; $display("FAIL reset_imem_addr: got %0h want 0", imem_addr); end
    checks++; if (ir_valid !== 1'b0)     begin errors++; $display("FAIL reset_ir_valid: got %0h want 0", ir_valid); end
    checks++; if (ir_out !== 32'd0)      begin errors++; $display("FAIL reset_ir_out: got %0h want 0", ir_out); end
    checks++; if (ir_pc !== 32'd0)       begin errors++; $display("FAIL reset_ir_pc: got %0h want 0", ir_pc); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count: got %0h want 0", fetch_count); end
    checks++; if (pc_ready !== 1'b1)     begin errors++; $display("FAIL reset_pc_ready: got %0h want 1", pc_ready); end
  endtask

  task automatic test_back_to_back();
    int next_pc = 0, n_out = 0, acc0 = -1, first_valid = -1;
    bit pv;
    do_reset();
    ack_delay = 0;
    for (int c = 0; c < 12; c++) begin
      pv = (next_pc < 3);
      drive(pv, next_pc, 1, 0);
      checks++; if (imem_req !== m_busy) begin errors++; $display("FAIL b2b_imem_req: got %0h want %0h", imem_req, m_busy); end
      if (m_busy) begin
        checks++; if (imem_addr !== m_addr) begin errors++; $display("FAIL b2b_imem_addr: got %0h want %0h", imem_addr, m_addr); end
      end
      if (ir_valid === 1'b1) begin
        checks++; if (ir_pc !== n_out) begin errors++; $display("FAIL b2b_ir_pc: got %0h want %0h", ir_pc, n_out); end
        checks++; if (ir_out !== mem_word(n_out)) begin errors++; $display("FAIL b2b_ir_out: got %0h want %0h", ir_out, mem_word(n_out)); end
        n_out++;
      end
      if (pv && exp_pc_ready()) begin
        if (acc0 < 0) acc0 = cyc;
        next_pc++;
      end
      tick();
      if (ir_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    end
    checks++; if (n_out != 3) begin errors++; $display("FAIL b2b_delivered: got %0d want 3", n_out); end
    // Accept at edge T; ir_valid is seen in cycle T+2, i.e. just after the following edge.
    checks++; if (first_valid - acc0 != 2) begin errors++; $display("FAIL b2b_first_latency: got %0d want 2", first_valid - acc0); end
  endtask

  task automatic test_backpressure();
    int next_pc = 10, seen = 0;
    bit pv;
    do_reset();
    ack_delay = 0;
    for (int c = 0; c < 10; c++) begin
      pv = (next_pc < 13);
      drive(pv, next_pc, 0, 0);
      checks++; if (pc_ready !== exp_pc_ready()) begin errors++; $display("FAIL bp_pc_ready: got %0h want %0h", pc_ready, exp_pc_ready()); end
      if (pv && exp_pc_ready()) next_pc++;
      tick();
    end
    drive(1, next_pc, 0, 0);
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pc_ready: got %0h want 0", pc_ready); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_imem_req: got %0h want 0", imem_req); end
    checks++; if (ir_pc !== 32'd10)  begin errors++; $display("FAIL bp_head_stable: got %0h want a", ir_pc); end
    checks++; if (next_pc != 12)     begin errors++; $display("FAIL bp_accepted: got %0d want 12", next_pc); end
    for (int c = 0; c < 20 && seen < 3; c++) begin
      pv = (next_pc < 13);
      drive(pv, next_pc, 1, 0);
      if (ir_valid === 1'b1) begin
        checks++; if (ir_pc !== 10 + seen) begin errors++; $display("FAIL bp_order_pc: got %0h want %0h", ir_pc, 10 + seen); end
        checks++; if (ir_out !== mem_word(10 + seen)) begin errors++; $display("FAIL bp_order_data: got %0h want %0h", ir_out, mem_word(10 + seen)); end
        seen++;
      end
      if (pv && exp_pc_ready()) next_pc++;
      tick();
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL bp_drained: got %0d want 3", seen); end
  endtask

  task automatic test_flush_inflight();
    bit acc = 0, fl;
    do_reset();
    ack_delay = 3;
    drive(1, 32'd5, 1, 0);
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL fi_accept: got %0h want 1", pc_ready); end
    tick();
    for (int c = 0; c < 8; c++) begin
      fl = m_busy && (m_wait == 2);
      drive(0, '0, 1, fl);
      checks++; if (imem_req !== (c < 4)) begin errors++; $display("FAIL fi_req_held c=%0d: got %0h want %0h", c, imem_req, c < 4); end
      checks++; if (ir_valid !== 1'b0)    begin errors++; $display("FAIL fi_no_valid c=%0d: got %0h want 0", c, ir_valid); end
      if (c < 4) begin
        checks++; if (imem_addr !== 32'd5) begin errors++; $display("FAIL fi_addr: got %0h want 5", imem_addr); end
      end
      tick();
    end
    ack_delay = 0;
    for (int c = 0; c < 6; c++) begin
      drive(!acc, 32'd9, 0, 0);
      if (!acc && exp_pc_ready()) acc = 1;
      tick();
    end
    drive(0, '0, 0, 0);
    checks++; if (ir_valid !== 1'b1)       begin errors++; $display("FAIL fi_refetch_valid: got %0h want 1", ir_valid); end
    checks++; if (ir_pc !== 32'd9)         begin errors++; $display("FAIL fi_refetch_pc: got %0h want 9", ir_pc); end
    checks++; if (ir_out !== mem_word(9))  begin errors++; $display("FAIL fi_refetch_data: got %0h want %0h", ir_out, mem_word(9)); end
  endtask

  task automatic test_flush_full();
    int next_pc = 20;
    do_reset();
    ack_delay = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1, next_pc, 0, 0);
      if (exp_pc_ready()) next_pc++;
      tick();
    end
    drive(1, 32'd30, 1, 1);
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL ff_full_valid: got %0h want 1", ir_valid); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL ff_flush_pc_ready: got %0h want 0", pc_ready); end
    tick();
    drive(1, 32'd30, 1, 0);
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL ff_emptied: got %0h want 0", ir_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_no_req: got %0h want 0", imem_req); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL ff_ready_after: got %0h want 1", pc_ready); end
    tick();
    drive(0, '0, 1, 0);
    checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL ff_req_after: got %0h want 1", imem_req); end
    checks++; if (imem_addr !== 32'd30) begin errors++; $display("FAIL ff_addr_after: got %0h want 1e", imem_addr); end
    tick();
  endtask

  task automatic test_reset_midreq();
    do_reset();
    ack_delay = 0;
    drive(1, 32'd31, 0, 0); tick();
    drive(0, '0, 0, 0);     tick();
    ack_delay = 5;
    drive(1, 32'd33, 0, 0); tick();
    drive(0, '0, 0, 0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_pre_req: got %0h want 1", imem_req); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %0h want 1", ir_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, '0, 0, 0);
    checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rm_req: got %0h want 0", imem_req); end
    checks++; if (ir_valid !== 1'b0)     begin errors++; $display("FAIL rm_valid: got %0h want 0", ir_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rm_count: got %0h want 0", fetch_count); end
    checks++; if (pc_ready !== 1'b1)     begin errors++; $display("FAIL rm_idle: got %0h want 1", pc_ready); end
  endtask

  task automatic test_fetch_count();
    int next_pc = 40, seen = 0;
    bit pv;
    logic [31:0] want;
    do_reset();
    ack_delay = 0;
    for (int c = 0; c < 30 && seen < 4; c++) begin
      pv = (next_pc < 44);
      drive(pv, next_pc, 1, 0);
      if (ir_valid === 1'b1) seen++;
      if (pv && exp_pc_ready()) next_pc++;
      tick();
    end
    drive(0, '0, 0, 1);
    tick();
    drive(0, '0, 0, 0);
`ifdef IF_FETCH_COUNT_EN
    want = 32'd4;
`else
    want = 32'd0;
`endif
    checks++; if (seen != 4)           begin errors++; $display("FAIL fc_delivered: got %0d want 4", seen); end
    checks++; if (fetch_count !== want) begin errors++; $display("FAIL fc_after_flush: got %0h want %0h", fetch_count, want); end
  endtask

  task automatic test_random();
    bit pv, rdy, fl;
    logic [63:0] head;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!m_busy) ack_delay = $urandom_range(0, 3);
      pv  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 15) == 0);
      drive(pv, $urandom, rdy, fl);
      checks++; if (pc_ready !== exp_pc_ready()) begin errors++; $display("FAIL rnd_pc_ready c=%0d: got %0h want %0h", c, pc_ready, exp_pc_ready()); end
      checks++; if (imem_req !== m_busy)         begin errors++; $display("FAIL rnd_imem_req c=%0d: got %0h want %0h", c, imem_req, m_busy); end
      checks++; if (imem_addr !== m_addr)        begin errors++; $display("FAIL rnd_imem_addr c=%0d: got %0h want %0h", c, imem_addr, m_addr); end
      checks++; if (ir_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_ir_valid c=%0d: got %0h want %0h", c, ir_valid, m_q.size() > 0); end
      checks++; if (fetch_count !== exp_count()) begin errors++; $display("FAIL rnd_fetch_count c=%0d: got %0h want %0h", c, fetch_count, exp_count()); end
      if (m_q.size() > 0) begin
        head = m_q[0];
        checks++; if (ir_pc !== head[63:32])  begin errors++; $display("FAIL rnd_ir_pc c=%0d: got %0h want %0h", c, ir_pc, head[63:32]); end
        checks++; if (ir_out !== head[31:0])  begin errors++; $display("FAIL rnd_ir_out c=%0d: got %0h want %0h", c, ir_out, head[31:0]); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush_inflight();
    test_flush_full();
    test_reset_midreq();
    test_fetch_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
